// File: rtl/rx_fifo_rd_sched.sv
// rtl/rx_fifo_rd_sched.sv - UART RX FIFO read-port scheduler for host words and DMA bursts
// Optional build macro: RX_WATERMARK_IRQ_EN adds the wm_level input and rx_irq output.
module rx_fifo_rd_sched #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              notempty,
  input  logic [LEN_W-1:0]  fifo_level,
  output logic              fiford,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              host_req,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              dma_req,
  input  logic [3:0]        dma_len,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [3:0]        dma_cnt
`ifdef RX_WATERMARK_IRQ_EN
  ,
  input  logic [LEN_W-1:0]  wm_level,
  output logic              rx_irq
`endif
);

  typedef enum logic [1:0] {IDLE, HOST_RD, DMA_RD, DRAIN} state_t;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_DMA  = 1'b1;
  // Every tag stage except the output stage.
  localparam logic [RD_LAT-1:0] LOW_MASK = {RD_LAT{1'b1}} >> 1;

  state_t            state;
  state_t            state_nxt;
  logic              last_owner;
  logic              dma_first;
  logic [3:0]        len_q;
  logic [3:0]        iss_cnt;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_dma;
  logic              host_elig;
  logic              dma_elig;
  logic              pick_host;
  logic              pick_dma;
  logic              dma_last_issue;
  logic              pipe_empty;
  logic              top_v;
  logic              top_dma;
  logic              dma_rlast_nxt;
  logic              dma_rlast_q;

  assign host_elig      = host_req & notempty;
  assign dma_elig       = dma_req && (dma_len != 4'd0) && (fifo_level >= LEN_W'(dma_len));
  // On a tie the requester that did not own the previous slot wins.
  assign pick_host      = host_elig && (!dma_elig || (last_owner == OWN_DMA));
  assign pick_dma       = dma_elig && !pick_host;
  assign dma_last_issue = ((iss_cnt + 4'd1) == len_q);
  assign pipe_empty     = (tag_v == '0);
  assign top_v          = tag_v[RD_LAT-1];
  assign top_dma        = tag_dma[RD_LAT-1];
  // The word leaving the tag pipe is the burst's last when nothing else is
  // in flight behind it and the issue phase is over (full or truncated).
  assign dma_rlast_nxt  = top_v && top_dma && !(|(tag_v & LOW_MASK)) &&
                          !((state == DMA_RD) && fiford);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: arbitration in IDLE, issue in HOST_RD/DMA_RD, wait for returns in DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_host)     state_nxt = HOST_RD;
        else if (pick_dma) state_nxt = DMA_RD;
      end
      HOST_RD: state_nxt = DRAIN;
      DMA_RD:  if (!notempty || dma_last_issue) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: read strobe and grant pulses; never strobe an empty FIFO.
  always_comb begin
    fiford   = 1'b0;
    host_gnt = 1'b0;
    dma_gnt  = 1'b0;
    case (state)
      HOST_RD: begin
        fiford   = notempty;
        host_gnt = notempty;
      end
      DMA_RD: begin
        fiford  = notempty;
        dma_gnt = dma_first;
      end
      default: ;
    endcase
  end

  // Grant bookkeeping: owner history, latched burst length and issue count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner <= OWN_DMA;
      dma_first  <= 1'b0;
      len_q      <= 4'd0;
      iss_cnt    <= 4'd0;
    end else begin
      dma_first <= 1'b0;
      if (state == IDLE && pick_host) last_owner <= OWN_HOST;
      if (state == IDLE && pick_dma) begin
        last_owner <= OWN_DMA;
        len_q      <= dma_len;
        iss_cnt    <= 4'd0;
        dma_first  <= 1'b1;
      end
      if (state == DMA_RD && fiford) iss_cnt <= iss_cnt + 4'd1;
    end
  end

  // Tag pipe tracking each issued read until its memory data is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v   <= '0;
      tag_dma <= '0;
    end else begin
      tag_v[0]   <= fiford;
      tag_dma[0] <= fiford && (state == DMA_RD);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_dma[i] <= tag_dma[i-1];
      end
    end
  end

  // Registered return steering, burst word count and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      dma_rvalid  <= 1'b0;
      dma_rdata   <= '0;
      dma_rlast_q <= 1'b0;
      dma_done    <= 1'b0;
      dma_cnt     <= 4'd0;
    end else begin
      host_rvalid <= top_v && !top_dma;
      dma_rvalid  <= top_v && top_dma;
      dma_rlast_q <= dma_rlast_nxt;
      dma_done    <= dma_rvalid && dma_rlast_q;
      if (top_v && !top_dma) host_rdata <= mem_rdata;
      if (top_v && top_dma)  dma_rdata  <= mem_rdata;
      if (state == IDLE && pick_dma)         dma_cnt <= 4'd0;
      else if (dma_rvalid && dma_cnt != 4'hf) dma_cnt <= dma_cnt + 4'd1;
    end
  end

`ifdef RX_WATERMARK_IRQ_EN
  logic dma_busy;
  // During DRAIN last_owner names the requester whose reads are still returning.
  assign dma_busy = (state == DMA_RD) || ((state == DRAIN) && (last_owner == OWN_DMA));

  // Watermark interrupt, suppressed while a DMA burst is draining the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) rx_irq <= 1'b0;
    else        rx_irq <= (wm_level != '0) && (fifo_level >= wm_level) && !dma_busy;
  end
`endif

endmodule

// File: tb/tb_rx_fifo_rd_sched.sv
// tb/tb_rx_fifo_rd_sched.sv - directed-vector bench for rx_fifo_rd_sched
module tb_rx_fifo_rd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       notempty = 1'b0;
  logic [5:0] fifo_level = '0;
  logic       host_req = 1'b0;
  logic       dma_req = 1'b0;
  logic [3:0] dma_len = '0;

  logic       fiford, host_gnt, host_rvalid, dma_gnt, dma_rvalid, dma_done;
  logic [7:0] host_rdata, dma_rdata;
  logic [3:0] dma_cnt;
  logic [7:0] mem1 = '0;
  logic [7:0] pop_cnt = '0;

  logic       ff3, hg3, hrv3, dg3, drv3, done3;
  logic [7:0] hrd3, drd3;
  logic [3:0] cnt3;
  logic [7:0] d3 [3] = '{8'h0, 8'h0, 8'h0};
  logic [7:0] pop3 = '0;

  always #5 clk = ~clk;

  rx_fifo_rd_sched #(.DATA_W(8), .LEN_W(6), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .notempty(notempty), .fifo_level(fifo_level),
    .fiford(fiford), .mem_rdata(mem1), .host_req(host_req), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .dma_req(dma_req),
    .dma_len(dma_len), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_cnt(dma_cnt));

  rx_fifo_rd_sched #(.DATA_W(8), .LEN_W(6), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .notempty(notempty), .fifo_level(fifo_level),
    .fiford(ff3), .mem_rdata(d3[2]), .host_req(host_req), .host_gnt(hg3),
    .host_rvalid(hrv3), .host_rdata(hrd3), .dma_req(dma_req),
    .dma_len(dma_len), .dma_gnt(dg3), .dma_rvalid(drv3),
    .dma_rdata(drd3), .dma_done(done3), .dma_cnt(cnt3));

  // Memory models: each pop returns a running index RD_LAT cycles later.
  always @(posedge clk) begin
    if (fiford) begin
      mem1    <= pop_cnt;
      pop_cnt <= pop_cnt + 8'd1;
    end
    d3[0] <= ff3 ? pop3 : 8'h00;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
    if (ff3) pop3 <= pop3 + 8'd1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; host_req = 1'b0; dma_req = 1'b0; dma_len = '0;
    notempty = 1'b0; fifo_level = '0;
    adv();
    rst_n = 1'b1;
  endtask

  // Monitor statistics for the RD_LAT=1 instance.
  int cyc, n_ff, ff_first, ff_last, ff_empty, n_hg, n_dg, n_hrv, hrv_first;
  int n_drv, drv_first, drv_last, n_done, done_cyc, cnt_at_done, data_err, both_rv;
  logic [7:0] exp_q[$];
  int gseq[$];

  task automatic clr_stats();
    cyc = 0; n_ff = 0; ff_first = -1; ff_last = -1; ff_empty = 0; n_hg = 0; n_dg = 0;
    n_hrv = 0; hrv_first = -1; n_drv = 0; drv_first = -1; drv_last = -1; n_done = 0;
    done_cyc = -1; cnt_at_done = -1; data_err = 0; both_rv = 0;
    exp_q.delete(); gseq.delete();
  endtask

  task automatic mon_cycle();
    logic [7:0] e;
    @(negedge clk);
    if (fiford) begin
      if (n_ff == 0) ff_first = cyc;
      ff_last = cyc;
      n_ff++;
      exp_q.push_back(pop_cnt);
      if (!notempty) ff_empty++;
    end
    if (host_gnt) begin n_hg++; gseq.push_back(0); end
    if (dma_gnt)  begin n_dg++; gseq.push_back(1); end
    if (host_rvalid && dma_rvalid) both_rv++;
    if (host_rvalid) begin
      n_hrv++;
      if (n_hrv == 1) hrv_first = cyc;
      if (exp_q.size() == 0) data_err++;
      else begin e = exp_q.pop_front(); if (e != host_rdata) data_err++; end
    end
    if (dma_rvalid) begin
      n_drv++;
      if (n_drv == 1) drv_first = cyc;
      drv_last = cyc;
      if (exp_q.size() == 0) data_err++;
      else begin e = exp_q.pop_front(); if (e != dma_rdata) data_err++; end
    end
    if (dma_done) begin n_done++; done_cyc = cyc; cnt_at_done = int'(dma_cnt); end
    adv();
    cyc++;
  endtask

  typedef struct {
    logic [5:0] lvl;
    logic       ne;
    logic       hreq;
    logic       dreq;
    logic [3:0] dlen;
    logic       exp_h;
    logic       exp_d;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bad;
    vecs[0] = '{6'd3,  1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[1] = '{6'd8,  1'b1, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
    vecs[2] = '{6'd2,  1'b1, 1'b1, 1'b1, 4'd4,  1'b1, 1'b0};
    vecs[3] = '{6'd8,  1'b1, 1'b1, 1'b1, 4'd4,  1'b1, 1'b0};
    vecs[4] = '{6'd0,  1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[5] = '{6'd8,  1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
    vecs[6] = '{6'd4,  1'b1, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
    vecs[7] = '{6'd3,  1'b1, 1'b0, 1'b1, 4'd4,  1'b0, 1'b0};
    vecs[8] = '{6'd15, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
    vecs[9] = '{6'd40, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      fifo_level = vecs[i].lvl; notempty = vecs[i].ne;
      host_req = vecs[i].hreq; dma_req = vecs[i].dreq; dma_len = vecs[i].dlen;
      @(negedge clk);
      chk($sformatf("v%0d_idle_fiford", i), int'(fiford), 0);
      chk($sformatf("v%0d_rst_cnt", i), int'(dma_cnt), 0);
      adv();
      @(negedge clk);
      chk($sformatf("v%0d_host_gnt", i), int'(host_gnt), int'(vecs[i].exp_h));
      chk($sformatf("v%0d_dma_gnt", i), int'(dma_gnt), int'(vecs[i].exp_d));
      chk($sformatf("v%0d_fiford", i), int'(fiford), int'(vecs[i].exp_h | vecs[i].exp_d));
      adv();
      host_req = 1'b0; dma_req = 1'b0;
      repeat (25) adv();
    end

    // Single host read at RD_LAT=1.
    do_reset();
    clr_stats();
    fifo_level = 6'd3; notempty = 1'b1; host_req = 1'b1;
    mon_cycle();
    host_req = 1'b0;
    repeat (7) mon_cycle();
    chk("host_gnt_cnt", n_hg, 1);
    chk("host_ff_cyc", ff_first, 1);
    chk("host_ff_cnt", n_ff, 1);
    chk("host_rv_cyc", hrv_first, 3);
    chk("host_rv_cnt", n_hrv, 1);
    chk("host_data", data_err, 0);

    // Full 4-word DMA burst.
    do_reset();
    clr_stats();
    fifo_level = 6'd8; notempty = 1'b1; dma_req = 1'b1; dma_len = 4'd4;
    mon_cycle();
    dma_req = 1'b0;
    repeat (12) mon_cycle();
    chk("burst_gnt_cnt", n_dg, 1);
    chk("burst_ff_cnt", n_ff, 4);
    chk("burst_ff_first", ff_first, 1);
    chk("burst_ff_last", ff_last, 4);
    chk("burst_rv_cnt", n_drv, 4);
    chk("burst_rv_first", drv_first, 3);
    chk("burst_rv_last", drv_last, 6);
    chk("burst_done_cyc", done_cyc, 7);
    chk("burst_done_cnt", n_done, 1);
    chk("burst_cnt", cnt_at_done, 4);
    chk("burst_data", data_err, 0);

    // DMA ineligible (level below length): host serviced repeatedly, DMA starves.
    do_reset();
    clr_stats();
    fifo_level = 6'd2; notempty = 1'b1; host_req = 1'b1; dma_req = 1'b1; dma_len = 4'd4;
    repeat (12) mon_cycle();
    chk("starve_dma_gnt", n_dg, 0);
    chk("starve_host_gnt", n_hg, 3);
    chk("starve_data", data_err, 0);

    // Round-robin with both requesters held.
    do_reset();
    clr_stats();
    fifo_level = 6'd8; notempty = 1'b1; host_req = 1'b1; dma_req = 1'b1; dma_len = 4'd2;
    repeat (30) mon_cycle();
    host_req = 1'b0; dma_req = 1'b0;
    repeat (8) mon_cycle();
    bad = 0;
    for (int k = 1; k < gseq.size(); k++) if (gseq[k] == gseq[k-1]) bad++;
    chk("rr_enough_grants", int'(gseq.size() >= 4), 1);
    chk("rr_first_host", (gseq.size() > 0) ? gseq[0] : -1, 0);
    chk("rr_alternation", bad, 0);
    chk("rr_both_rvalid", both_rv, 0);
    chk("rr_data", data_err, 0);

    // Truncated burst: FIFO runs empty after 3 issues.
    do_reset();
    clr_stats();
    fifo_level = 6'd8; notempty = 1'b1; dma_req = 1'b1; dma_len = 4'd6;
    mon_cycle();
    dma_req = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (n_ff >= 3) notempty = 1'b0;
      mon_cycle();
    end
    chk("trunc_ff_cnt", n_ff, 3);
    chk("trunc_ff_empty", ff_empty, 0);
    chk("trunc_rv_cnt", n_drv, 3);
    chk("trunc_done_cnt", n_done, 1);
    chk("trunc_done_cyc", done_cyc, drv_last + 1);
    chk("trunc_cnt", cnt_at_done, 3);
    chk("trunc_data", data_err, 0);

    // Reset mid-burst on the RD_LAT=3 instance, then host wins the first tie.
    begin
      int rv_after, done_after, first_g, first_g_cyc;
      do_reset();
      fifo_level = 6'd8; notempty = 1'b1; dma_req = 1'b1; dma_len = 4'd8;
      adv(); adv(); adv();
      @(negedge clk);
      chk("lat3_issuing", int'(ff3), 1);
      rst_n = 1'b0;
      adv();
      rst_n = 1'b1; host_req = 1'b1;
      @(negedge clk);
      chk("lat3_rst_outs", int'({ff3, hg3, hrv3, dg3, drv3, done3}), 0);
      chk("lat3_rst_cnt", int'(cnt3), 0);
      chk("lat3_rst_rdata", int'({hrd3, drd3}), 0);
      rv_after = 0; done_after = 0; first_g = -1; first_g_cyc = -1;
      for (int k = 0; k < 10; k++) begin
        adv();
        @(negedge clk);
        if (k == 0) host_req = 1'b1;
        if (drv3) rv_after++;
        if (done3) done_after++;
        if (first_g < 0 && hg3) begin first_g = 0; first_g_cyc = k; end
        if (first_g < 0 && dg3) begin first_g = 1; first_g_cyc = k; end
        if (first_g >= 0) host_req = 1'b0;
      end
      chk("lat3_no_rvalid", rv_after, 0);
      chk("lat3_no_done", done_after, 0);
      chk("lat3_host_first", first_g, 0);
      chk("lat3_host_cyc", first_g_cyc, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
